// File: rtl/main_vc_sched_if.sv
// Signal bundle between the VC scheduler, the Main FIFO read port and the
// two VC FIFO write ports. The scheduler takes the master side.
interface main_vc_sched_if #(
  parameter int BW = 6,
  parameter int TW = 3
);
  logic          init;
  logic [TW-1:0] umbral_main_in;
  logic [TW-1:0] umbral_vc_in;
  logic          main_empty;
  logic [BW-1:0] main_data_out;
  logic          main_error;
  logic          vc0_almost_full;
  logic          vc1_almost_full;
  logic          vc0_error;
  logic          vc1_error;

  logic          main_rd;
  logic          vc0_wr;
  logic          vc1_wr;
  logic [BW-1:0] vc_data;
  logic [TW-1:0] umbral_main_out;
  logic [TW-1:0] umbral_vc_out;
  logic [2:0]    state;
  logic          idle;
  logic          error_out;

  modport master (
    input  init, umbral_main_in, umbral_vc_in, main_empty, main_data_out,
           main_error, vc0_almost_full, vc1_almost_full, vc0_error, vc1_error,
    output main_rd, vc0_wr, vc1_wr, vc_data, umbral_main_out, umbral_vc_out,
           state, idle, error_out
  );

  modport slave (
    output init, umbral_main_in, umbral_vc_in, main_empty, main_data_out,
           main_error, vc0_almost_full, vc1_almost_full, vc0_error, vc1_error,
    input  main_rd, vc0_wr, vc1_wr, vc_data, umbral_main_out, umbral_vc_out,
           state, idle, error_out
  );
endinterface

// File: rtl/main_vc_sched.sv
// QoS datapath controller: loads FIFO thresholds, drains the Main FIFO and
// steers each word to VC0/VC1 by its class bit under VC backpressure.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RESET  | just out of reset; always moves to INIT
// INIT   | thresholds track their inputs; leaves when init drops
// IDLE   | thresholds held; waits for Main FIFO data or a re-init request
// ACTIVE | issuing reads; returns to IDLE once empty with nothing in flight
// ERROR  | sticky after any FIFO error; in-flight word dropped; reset only
module main_vc_sched #(
  parameter int BW      = 6,
  parameter int TW      = 3,
  parameter int CLS_BIT = 5
) (
  input  logic             clk,
  input  logic             reset,
  main_vc_sched_if.master  bus
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          pending_q, pending_d;
  logic [TW-1:0] umbral_main_q, umbral_main_d;
  logic [TW-1:0] umbral_vc_q, umbral_vc_d;
  logic          any_error;
  logic          rd_issue;
  logic          cls;

  assign any_error = bus.main_error | bus.vc0_error | bus.vc1_error;
  assign cls       = bus.main_data_out[CLS_BIT];

  // Both almost-full flags gate the read: the class is only known once the
  // word comes back, so either VC may be the destination.
  assign rd_issue = (state_q == S_ACTIVE) & ~bus.main_empty &
                    ~bus.vc0_almost_full & ~bus.vc1_almost_full & ~bus.init;

  // State, in-flight flag and threshold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RESET;
      pending_q     <= 1'b0;
      umbral_main_q <= '0;
      umbral_vc_q   <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      umbral_main_q <= umbral_main_d;
      umbral_vc_q   <= umbral_vc_d;
    end
  end

  // Next state and threshold capture; errors win over every other transition.
  always_comb begin
    state_d       = state_q;
    umbral_main_d = umbral_main_q;
    umbral_vc_d   = umbral_vc_q;
    pending_d     = rd_issue;
    if (state_q == S_INIT) begin
      umbral_main_d = bus.umbral_main_in;
      umbral_vc_d   = bus.umbral_vc_in;
    end
    if (state_q == S_RESET) begin
      state_d = S_INIT;
    end else if (any_error) begin
      state_d = S_ERROR;
    end else begin
      unique case (state_q)
        S_INIT:   if (!bus.init) state_d = S_IDLE;
        S_IDLE: begin
          if (bus.init)             state_d = S_INIT;
          else if (!bus.main_empty) state_d = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (bus.init)                           state_d = S_INIT;
          else if (bus.main_empty && !pending_q)  state_d = S_IDLE;
        end
        S_ERROR:  state_d = S_ERROR;
        default:  state_d = S_ERROR;
      endcase
    end
  end

  // Outputs; reset forces everything low at once so an in-flight word never
  // reaches a VC FIFO during reset.
  always_comb begin
    bus.main_rd         = 1'b0;
    bus.vc0_wr          = 1'b0;
    bus.vc1_wr          = 1'b0;
    bus.vc_data         = '0;
    bus.umbral_main_out = '0;
    bus.umbral_vc_out   = '0;
    bus.state           = S_RESET;
    bus.idle            = 1'b0;
    bus.error_out       = 1'b0;
    if (!reset) begin
      bus.main_rd         = rd_issue;
      bus.vc0_wr          = pending_q & ~cls & (state_q != S_ERROR);
      bus.vc1_wr          = pending_q &  cls & (state_q != S_ERROR);
      bus.vc_data         = bus.main_data_out;
      bus.umbral_main_out = umbral_main_q;
      bus.umbral_vc_out   = umbral_vc_q;
      bus.state           = state_q;
      bus.idle            = (state_q == S_IDLE);
      bus.error_out       = (state_q == S_ERROR);
    end
  end

endmodule

// File: tb/tb_main_vc_sched.sv
// Directed bench for main_vc_sched: inputs change on the falling edge and
// outputs are checked 1 ns later, so registered values reflect the last
// rising edge and combinational ones the inputs just applied.
module tb_main_vc_sched;
  localparam int BW = 6;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  main_vc_sched_if #(.BW(BW), .TW(TW)) bus ();

  main_vc_sched #(.BW(BW), .TW(TW), .CLS_BIT(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".state"},     32'(bus.state), 0);
    chk({tag, ".idle"},      32'(bus.idle), 0);
    chk({tag, ".error_out"}, 32'(bus.error_out), 0);
    chk({tag, ".main_rd"},   32'(bus.main_rd), 0);
    chk({tag, ".vc0_wr"},    32'(bus.vc0_wr), 0);
    chk({tag, ".vc1_wr"},    32'(bus.vc1_wr), 0);
    chk({tag, ".vc_data"},   32'(bus.vc_data), 0);
    chk({tag, ".umb_main"},  32'(bus.umbral_main_out), 0);
    chk({tag, ".umb_vc"},    32'(bus.umbral_vc_out), 0);
  endtask

  initial begin
    reset                = 1'b1;
    bus.init             = 1'b1;
    bus.umbral_main_in   = 3'd5;
    bus.umbral_vc_in     = 3'd6;
    bus.main_empty       = 1'b0;
    bus.main_data_out    = 6'h2A;
    bus.main_error       = 1'b0;
    bus.vc0_almost_full  = 1'b0;
    bus.vc1_almost_full  = 1'b0;
    bus.vc0_error        = 1'b0;
    bus.vc1_error        = 1'b0;

    // Reset held two cycles with busy-looking inputs: outputs must stay 0.
    tick(); settle(); chk_all_zero("rst1");
    tick(); settle(); chk_all_zero("rst2");

    // Reset release and threshold load.
    tick(); reset = 1'b0; bus.init = 1'b0; bus.main_empty = 1'b1;
    bus.umbral_main_in = 3'd3; bus.umbral_vc_in = 3'd2;
    settle(); chk("c0.state", 32'(bus.state), 0); chk("c0.main_rd", 32'(bus.main_rd), 0);
    tick(); bus.init = 1'b1;
    settle(); chk("c1.state", 32'(bus.state), 1);
    tick(); bus.init = 1'b1;
    settle(); chk("c2.state", 32'(bus.state), 1);
    chk("c2.umb_main", 32'(bus.umbral_main_out), 3); chk("c2.umb_vc", 32'(bus.umbral_vc_out), 2);
    tick(); bus.init = 1'b0;
    settle(); chk("c3.state", 32'(bus.state), 1);
    tick(); bus.umbral_main_in = 3'd7; bus.umbral_vc_in = 3'd5;
    settle(); chk("c4.state", 32'(bus.state), 2); chk("c4.idle", 32'(bus.idle), 1);
    chk("c4.umb_main", 32'(bus.umbral_main_out), 3); chk("c4.umb_vc", 32'(bus.umbral_vc_out), 2);
    tick();
    settle(); chk("c5.umb_main", 32'(bus.umbral_main_out), 3); chk("c5.umb_vc", 32'(bus.umbral_vc_out), 2);

    // Routing: FIFO holds 0x21 (class 1) then 0x05 (class 0).
    tick(); bus.main_empty = 1'b0;
    settle(); chk("a0.main_rd", 32'(bus.main_rd), 0);
    tick();
    settle(); chk("a1.state", 32'(bus.state), 3); chk("a1.main_rd", 32'(bus.main_rd), 1);
    chk("a1.vc0_wr", 32'(bus.vc0_wr), 0); chk("a1.vc1_wr", 32'(bus.vc1_wr), 0);
    tick(); bus.main_data_out = 6'h21;
    settle(); chk("a2.main_rd", 32'(bus.main_rd), 1); chk("a2.vc1_wr", 32'(bus.vc1_wr), 1);
    chk("a2.vc0_wr", 32'(bus.vc0_wr), 0); chk("a2.vc_data", 32'(bus.vc_data), 'h21);
    tick(); bus.main_empty = 1'b1; bus.main_data_out = 6'h05;
    settle(); chk("a3.main_rd", 32'(bus.main_rd), 0); chk("a3.vc0_wr", 32'(bus.vc0_wr), 1);
    chk("a3.vc1_wr", 32'(bus.vc1_wr), 0); chk("a3.vc_data", 32'(bus.vc_data), 'h05);
    chk("a3.state", 32'(bus.state), 3);
    tick();
    settle(); chk("a4.state", 32'(bus.state), 3); chk("a4.vc0_wr", 32'(bus.vc0_wr), 0);
    tick();
    settle(); chk("a5.state", 32'(bus.state), 2);

    // Backpressure from VC1 almost-full.
    tick(); bus.main_empty = 1'b0; bus.vc1_almost_full = 1'b1; bus.main_data_out = 6'h3F;
    settle(); chk("b0.main_rd", 32'(bus.main_rd), 0);
    tick();
    settle(); chk("b1.state", 32'(bus.state), 3); chk("b1.main_rd", 32'(bus.main_rd), 0);
    chk("b1.vc0_wr", 32'(bus.vc0_wr), 0); chk("b1.vc1_wr", 32'(bus.vc1_wr), 0);
    tick();
    settle(); chk("b2.main_rd", 32'(bus.main_rd), 0); chk("b2.vc1_wr", 32'(bus.vc1_wr), 0);

    // Flag drops: read issues; VC0 error in the same cycle drops the word.
    tick(); bus.vc1_almost_full = 1'b0; bus.vc0_error = 1'b1;
    settle(); chk("b3.main_rd", 32'(bus.main_rd), 1);
    tick(); bus.vc0_error = 1'b0; bus.main_data_out = 6'h01;
    settle(); chk("b4.state", 32'(bus.state), 4); chk("b4.error_out", 32'(bus.error_out), 1);
    chk("b4.vc0_wr", 32'(bus.vc0_wr), 0); chk("b4.vc1_wr", 32'(bus.vc1_wr), 0);
    chk("b4.main_rd", 32'(bus.main_rd), 0); chk("b4.idle", 32'(bus.idle), 0);
    tick(); bus.init = 1'b1;
    settle(); chk("b5.state", 32'(bus.state), 4); chk("b5.main_rd", 32'(bus.main_rd), 0);
    tick(); bus.init = 1'b0;
    settle(); chk("b6.state", 32'(bus.state), 4);

    // Reset out of ERROR, then load new thresholds 4/3.
    tick(); reset = 1'b1; bus.main_empty = 1'b1;
    settle(); chk_all_zero("e0");
    tick(); reset = 1'b0; bus.init = 1'b1; bus.umbral_main_in = 3'd4; bus.umbral_vc_in = 3'd3;
    settle(); chk("e1.state", 32'(bus.state), 0);
    tick();
    settle(); chk("e2.state", 32'(bus.state), 1);
    tick(); bus.init = 1'b0;
    settle(); chk("e3.state", 32'(bus.state), 1);
    chk("e3.umb_main", 32'(bus.umbral_main_out), 4); chk("e3.umb_vc", 32'(bus.umbral_vc_out), 3);

    // Re-init while a read is in flight: the write completes, then INIT.
    tick(); bus.main_empty = 1'b0;
    settle(); chk("e4.state", 32'(bus.state), 2);
    tick();
    settle(); chk("e5.state", 32'(bus.state), 3); chk("e5.main_rd", 32'(bus.main_rd), 1);
    tick(); bus.init = 1'b1; bus.main_data_out = 6'h20; bus.umbral_main_in = 3'd6; bus.umbral_vc_in = 3'd1;
    settle(); chk("e6.main_rd", 32'(bus.main_rd), 0); chk("e6.vc1_wr", 32'(bus.vc1_wr), 1);
    chk("e6.vc0_wr", 32'(bus.vc0_wr), 0); chk("e6.vc_data", 32'(bus.vc_data), 'h20);
    tick(); bus.init = 1'b0;
    settle(); chk("e7.state", 32'(bus.state), 1); chk("e7.main_rd", 32'(bus.main_rd), 0);
    chk("e7.vc1_wr", 32'(bus.vc1_wr), 0);
    tick();
    settle(); chk("e8.state", 32'(bus.state), 2);
    chk("e8.umb_main", 32'(bus.umbral_main_out), 6); chk("e8.umb_vc", 32'(bus.umbral_vc_out), 1);
    tick();
    settle(); chk("e9.state", 32'(bus.state), 3); chk("e9.main_rd", 32'(bus.main_rd), 1);

    // Reset the cycle after a read: the returning word is never written.
    tick(); reset = 1'b1; bus.main_data_out = 6'h25;
    settle(); chk_all_zero("r0");
    tick(); reset = 1'b0; bus.main_empty = 1'b1;
    settle(); chk("r1.state", 32'(bus.state), 0);
    chk("r1.vc0_wr", 32'(bus.vc0_wr), 0); chk("r1.vc1_wr", 32'(bus.vc1_wr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
